// File: rtl/reaction_ctrl_pkg.sv
// ============================================================================
// Module   : reaction_ctrl_pkg
// Purpose  : Shared definitions for the reaction-timer control stage. Holds
//            the trial FSM state encoding, the BCD limits and a helper that
//            advances a 4-digit BCD value by one.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package reaction_ctrl_pkg;

  // Trial FSM state encoding (3-bit)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_GO     = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_FOUL   = 3'd5;

  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  // Adds one to a 4-digit BCD value. A digit at 9 rolls to 0 and carries
  // into the next digit; the caller is responsible for saturation.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reaction_ctrl_bcd4_counter.sv
// ============================================================================
// Module   : bcd4_counter
// Purpose  : 4-digit BCD up-counter, saturating at 9999, synchronous clear.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-low reset
//            clr   - synchronous clear to 0000 (wins over inc)
//            inc   - count enable, one step per asserted cycle
//            q     - current BCD count
//            sat   - high while q == 9999
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd4_counter
  import reaction_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        sat
);

  logic [15:0] r_q;
  logic        w_sat;

  assign w_sat = (r_q == BCD_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= BCD_ZERO;
    end else if (clr) begin
      r_q <= BCD_ZERO;
    end else if (inc && !w_sat) begin
      r_q <= bcd_inc(r_q);
    end
  end

  assign q   = r_q;
  assign sat = w_sat;

endmodule

`default_nettype wire

// File: rtl/reaction_ctrl.sv
// ============================================================================
// Module   : reaction_ctrl
// Purpose  : Control and timing stage of the reaction timer. Arms the random
//            delay block, lights GO, measures the response in BCD ms and
//            hands the result to the scoring unit with a one-cycle strobe.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-low reset
//            start       - start-trial request (level)
//            react       - player button (level, pre-debounced)
//            delay_done  - delay block down-counter is zero
//            delay_ld    - load strobe to delay block
//            delay_en    - enable to delay block (LFSR + counter)
//            led_go      - GO indicator
//            false_start - sticky foul flag for the current trial
//            sc_in       - 16-bit BCD reaction time to scoring unit
//            sc_update   - one-cycle result strobe to scoring unit
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reaction_ctrl
  import reaction_ctrl_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int PRESC_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        react,
  input  logic        delay_done,
  output logic        delay_ld,
  output logic        delay_en,
  output logic        led_go,
  output logic        false_start,
  output logic [15:0] sc_in,
  output logic        sc_update
);

  localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(CLK_PER_MS - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [PRESC_W-1:0] r_presc;
  logic               w_presc_wrap;
  logic               w_tick;
  logic               w_clr;
  logic [15:0]        w_count;
  logic               w_sat;

  // Outputs are registered from the next state so that every output reads
  // 0 while reset is held, even though IDLE itself drives delay_en high.
  logic               r_delay_ld;
  logic               r_delay_en;
  logic               r_led_go;
  logic               r_false_start;
  logic [15:0]        r_sc_in;
  logic               r_sc_update;

  assign w_presc_wrap = (r_presc == C_PRESC_LAST);
  // A tick coinciding with react is dropped so the reported time is the
  // count the player actually beat.
  assign w_tick       = (r_state == S_GO) && w_presc_wrap && !react;
  assign w_clr        = (r_state == S_ARM);

  bcd4_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_tick),
    .q     (w_count),
    .sat   (w_sat)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start && !react) w_next = S_ARM;
      S_ARM:    w_next = S_WAIT;
      // react outranks delay_done: pressing early is a foul even if GO
      // would have lit on the same edge.
      S_WAIT:   if (react)           w_next = S_FOUL;
                else if (delay_done) w_next = S_GO;
      S_GO:     if (react || w_sat)  w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      S_FOUL:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_delay_ld    <= 1'b0;
      r_delay_en    <= 1'b0;
      r_led_go      <= 1'b0;
      r_false_start <= 1'b0;
      r_sc_in       <= BCD_ZERO;
      r_sc_update   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_ARM) begin
        r_presc <= '0;
      end else if (r_state == S_GO) begin
        r_presc <= w_presc_wrap ? '0 : r_presc + PRESC_W'(1);
      end

      r_delay_ld  <= (w_next == S_ARM);
      r_delay_en  <= (w_next == S_IDLE) || (w_next == S_ARM) || (w_next == S_WAIT);
      r_led_go    <= (w_next == S_GO);
      r_sc_update <= (w_next == S_REPORT) || (w_next == S_FOUL);

      // sc_in and false_start hold between trials; they change only when
      // a new trial arms or a result is produced.
      if (w_next == S_ARM) begin
        r_false_start <= 1'b0;
        r_sc_in       <= BCD_ZERO;
      end else if (w_next == S_REPORT) begin
        r_sc_in       <= w_count;
      end else if (w_next == S_FOUL) begin
        r_false_start <= 1'b1;
        r_sc_in       <= BCD_MAX;
      end
    end
  end

  assign delay_ld    = r_delay_ld;
  assign delay_en    = r_delay_en;
  assign led_go      = r_led_go;
  assign false_start = r_false_start;
  assign sc_in       = r_sc_in;
  assign sc_update   = r_sc_update;

endmodule

`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
// ============================================================================
// Module   : tb_reaction_ctrl
// Purpose  : Directed self-checking bench for reaction_ctrl (CLK_PER_MS=4).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic        delay_done = 1'b0;
  logic        delay_ld;
  logic        delay_en;
  logic        led_go;
  logic        false_start;
  logic [15:0] sc_in;
  logic        sc_update;

  int n_vec = 0;
  int n_err = 0;
  int n_double = 0;
  logic r_prev_upd = 1'b0;

  // Scoring-unit reference: best resets to 9999, last to 0000.
  logic [15:0] sm_last = 16'h0000;
  logic [15:0] sm_best = 16'h9999;

  always #5 clk = ~clk;

  reaction_ctrl #(
    .CLK_PER_MS (4),
    .PRESC_W    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .react       (react),
    .delay_done  (delay_done),
    .delay_ld    (delay_ld),
    .delay_en    (delay_en),
    .led_go      (led_go),
    .false_start (false_start),
    .sc_in       (sc_in),
    .sc_update   (sc_update)
  );

  // sc_update must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (sc_update && r_prev_upd) n_double++;
    r_prev_upd = sc_update;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic score(input logic [15:0] v);
    sm_last = v;
    if (v < sm_best) sm_best = v;
  endtask

  // From an IDLE falling edge: start, hold WAIT for extra cycles, fire
  // delay_done, press react during GO cycle k. Expected time is (k-1)/4.
  task automatic do_trial(input string tag, input int wait_cyc, input int k,
                          input logic [15:0] exp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_ld"}, delay_ld, 1);
    check_eq({tag, "_arm_fs"}, false_start, 0);
    check_eq({tag, "_arm_scin"}, sc_in, 16'h0000);
    @(negedge clk);
    check_eq({tag, "_ld_once"}, delay_ld, 0);
    repeat (wait_cyc) @(negedge clk);
    check_eq({tag, "_wait_go"}, led_go, 0);
    delay_done = 1'b1;
    @(negedge clk);
    delay_done = 1'b0;
    check_eq({tag, "_go"}, led_go, 1);
    check_eq({tag, "_go_en"}, delay_en, 0);
    repeat (k - 1) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    check_eq({tag, "_upd"}, sc_update, 1);
    check_eq({tag, "_scin"}, sc_in, exp);
    check_eq({tag, "_go_off"}, led_go, 0);
    if (sc_update) score(sc_in);
    @(negedge clk);
    check_eq({tag, "_upd_end"}, sc_update, 0);
    check_eq({tag, "_hold"}, sc_in, exp);
  endtask

  task automatic do_foul(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    react = 1'b1;
    delay_done = 1'b1;
    @(negedge clk);
    check_eq({tag, "_fs"}, false_start, 1);
    check_eq({tag, "_scin"}, sc_in, 16'h9999);
    check_eq({tag, "_upd"}, sc_update, 1);
    check_eq({tag, "_go"}, led_go, 0);
    if (sc_update) score(sc_in);
    react = 1'b0;
    delay_done = 1'b0;
    @(negedge clk);
    check_eq({tag, "_upd_end"}, sc_update, 0);
    check_eq({tag, "_fs_hold"}, false_start, 1);
    check_eq({tag, "_go_never"}, led_go, 0);
  endtask

  // From IDLE: start and reach the falling edge of GO cycle 1.
  task automatic enter_go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    delay_done = 1'b1;
    @(negedge clk);
    delay_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;

    // Reset state
    @(negedge clk);
    check_eq("rst_ld", delay_ld, 0);
    check_eq("rst_en", delay_en, 0);
    check_eq("rst_go", led_go, 0);
    check_eq("rst_fs", false_start, 0);
    check_eq("rst_scin", sc_in, 16'h0000);
    check_eq("rst_upd", sc_update, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_en", delay_en, 1);
    check_eq("idle_ld", delay_ld, 0);

    // Normal trial and BCD carry boundaries
    do_trial("normal", 3, 4*123 + 2, 16'h0123);
    do_trial("b9", 0, 40, 16'h0009);
    do_trial("b10", 1, 41, 16'h0010);
    do_trial("b99", 0, 400, 16'h0099);
    do_trial("b100", 2, 401, 16'h0100);

    // False start, then next trial clears the foul flag
    do_foul("foul");
    do_trial("after_foul", 0, 9, 16'h0002);

    // Start gating by react in IDLE, start ignored during GO
    react = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_eq("gate_idle1", delay_ld, 0);
    @(negedge clk);
    check_eq("gate_idle2", delay_ld, 0);
    react = 1'b0;
    @(negedge clk);
    check_eq("gate_arm", delay_ld, 1);
    start = 1'b0;
    @(negedge clk);
    delay_done = 1'b1;
    @(negedge clk);
    delay_done = 1'b0;
    check_eq("gate_go", led_go, 1);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    check_eq("gate_scin", sc_in, 16'h0005);
    check_eq("gate_upd", sc_update, 1);
    @(negedge clk);

    // Asynchronous reset mid-GO at count 0042
    enter_go();
    repeat (168) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_go", led_go, 0);
    check_eq("mid_rst_en", delay_en, 0);
    check_eq("mid_rst_scin", sc_in, 16'h0000);
    check_eq("mid_rst_upd", sc_update, 0);
    @(negedge clk);
    check_eq("mid_rst_upd2", sc_update, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_en", delay_en, 1);
    check_eq("post_rst_go", led_go, 0);
    do_trial("post_rst", 0, 5, 16'h0001);

    // Timeout: count saturates at 9999, REPORT in GO-relative cycle 39998
    enter_go();
    idx = 1;
    while (!sc_update && idx < 40100) begin
      @(negedge clk);
      idx++;
    end
    check_eq("to_latency", idx, 39998);
    check_eq("to_scin", sc_in, 16'h9999);
    check_eq("to_fs", false_start, 0);
    @(negedge clk);
    check_eq("to_upd_end", sc_update, 0);
    check_eq("to_hold", sc_in, 16'h9999);

    // Scoring integration: 0250, 0180, then a foul
    sm_last = 16'h0000;
    sm_best = 16'h9999;
    do_trial("int1", 2, 1001, 16'h0250);
    do_trial("int2", 1, 721, 16'h0180);
    check_eq("int_last2", sm_last, 16'h0180);
    check_eq("int_best2", sm_best, 16'h0180);
    do_foul("int3");
    check_eq("int_last3", sm_last, 16'h9999);
    check_eq("int_best3", sm_best, 16'h0180);

    check_eq("no_double_upd", n_double, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Control and timing stage of the reaction-timer datapath.
- Sequences one trial:
  - arms and runs the random-delay block;
  - lights the GO indicator;
  - measures the player's response in BCD milliseconds;
  - hands the result to the scoring unit as a 16-bit BCD time plus a one-cycle update strobe.
- Sits upstream of the scoring unit and drives the load/enable of the delay block.

Parameters:
- CLK_PER_MS, 50000: clock cycles per 1 ms tick. Legal range is ≥2.
- PRESC_W, 16: prescaler counter width. Must satisfy 2^PRESC_W ≥ CLK_PER_MS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 resets the block.
- start  in  1  start-trial request, level sampled.
- react  in  1  player button, level sampled, already synchronised/debounced upstream.
- delay_done  in  1  from delay block, high when its down-counter is zero.
- delay_ld  out  1  load strobe to delay block.
- delay_en  out  1  enable to delay block, which clocks both its LFSR and its counter.
- led_go  out  1  GO indicator.
- false_start  out  1  sticky foul flag for the current trial.
- sc_in  out  16  BCD reaction time, 4 digits, to scoring unit SCin.
- sc_update  out  1  one-cycle strobe to scoring unit SCupdate.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; prescaler=0; BCD count=0.
  - All outputs 0, including sc_in=16'h0000.
  - Reset mid-trial aborts immediately and issues no sc_update.
- delay_en is high in IDLE, ARM and WAIT, so the LFSR free-runs between trials. It is 0 in GO, REPORT and FOUL.
- IDLE:
  - Go to ARM when start=1 and react=0. start while react=1 is ignored.
  - Outputs hold their last values; false_start holds.
- ARM (1 cycle):
  - delay_ld=1; BCD count←0; prescaler←0; false_start←0; sc_in←0.
  - Go to WAIT.
- WAIT:
  - delay_done is sampled only from the first WAIT cycle onward, since the delay block reloads at the ARM edge.
  - react=1 → FOUL. react has priority over a simultaneous delay_done.
  - Else delay_done=1 → GO.
- GO:
  - led_go=1. The prescaler counts 0..CLK_PER_MS-1 and wraps; each wrap increments the 4-digit BCD count.
  - BCD digit carry 9→0 ripples to the next digit.
  - The count saturates at 9999. Reaching 9999 → REPORT with a timeout result.
  - react=1 → REPORT. A tick in the same cycle is discarded, so sc_in equals the count before that tick.
  - Latency: react sampled at edge N → sc_update high during cycle N+1.
- REPORT (1 cycle):
  - sc_in←BCD count (registered on entry); sc_update=1; led_go=0.
  - Go to IDLE.
- FOUL (1 cycle):
  - false_start←1; sc_in←16'h9999; sc_update=1.
  - Go to IDLE.
  - The penalty never beats an existing best, because the scoring unit's best register resets to 9999.
- sc_in holds its value from REPORT/FOUL until the next ARM. sc_update is never high for two consecutive cycles.
- start is ignored outside IDLE.
- Holding start high re-arms on the first IDLE cycle after react is released.

Decomposition:
- Shared package:
  - state enum IDLE/ARM/WAIT/GO/REPORT/FOUL, 3-bit encoding;
  - BCD_MAX=16'h9999;
  - BCD_ZERO=16'h0000.
- Sub-module bcd4_counter: 4-digit BCD up-counter.
  - Inputs: clk, reset, clr, inc.
  - Outputs: q[15:0] and sat (q==9999).
  - Saturating, with synchronous clear.
- The prescaler and FSM live in reaction_ctrl.

Test Plan (CLK_PER_MS=4):
- Normal trial: start pulse → delay_ld for exactly 1 cycle. Force delay_done=1 three cycles later → led_go=1. Assert react 4*123+2 cycles into GO → sc_update one cycle with sc_in=16'h0123, then IDLE with led_go=0.
- False start: start, then react=1 during WAIT with delay_done=1 the same cycle → FOUL. sc_in=16'h9999, false_start=1, sc_update one cycle, led_go never asserted.
- Timeout: GO with react held 0 → count passes 0009→0010 and 0099→0100 correctly. At 4*9999 ticks, sc_in=16'h9999 with sc_update; no wrap to 0000.
- Reset mid-GO: reset=0 asynchronously at count 0042 → all outputs 0 before the next clk edge, no sc_update. Release → IDLE, and a start works normally.
- Start gating: start=1 with react=1 in IDLE → stays IDLE. Release react → ARM next cycle. start pulses during GO are ignored (count unaffected).
- Integration with delay + scoringUnit: two trials of 0250 then 0180 → SCout shows last=0180, best=0180. A third trial fouls → last=9999, best stays 0180.
